// File: rtl/hcsr04_emulator_if.sv
// Sensor-side handshake bundle for the HC-SR04 emulator.
// master: the measuring block (drives trigger and the programmed distance).
// slave:  the emulator (answers with echo, busy and the accepted-trigger count).
interface hcsr04_emulator_if;
    logic        trigger;
    logic [15:0] dist_ticks;
    logic        echo;
    logic        busy;
    logic [7:0]  pulse_count;

    modport master (
        output trigger,
        output dist_ticks,
        input  echo,
        input  busy,
        input  pulse_count
    );

    modport slave (
        input  trigger,
        input  dist_ticks,
        output echo,
        output busy,
        output pulse_count
    );
endinterface

// File: rtl/hcsr04_emulator.sv
// HC-SR04 ultrasonic sensor emulator: qualifies a trigger pulse, waits a fixed
// burst delay, then drives an echo pulse whose width is the programmed distance
// in ticks of CLK_DIV clock cycles.
// Optional build macro HCSR04_EMULATOR_JITTER_EN adds 0..3 ticks of LFSR jitter
// to each echo width (saturating at MAX_ECHO_TICKS).
module hcsr04_emulator #(
    parameter int unsigned CLK_DIV          = 500,
    parameter int unsigned TRIG_MIN_TICKS   = 1,
    parameter int unsigned ECHO_DELAY_TICKS = 46,
    parameter int unsigned MAX_ECHO_TICKS   = 3800,
    parameter int unsigned HOLDOFF_TICKS    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    hcsr04_emulator_if.slave bus
);
    localparam logic [31:0] TrigMinCyc = 32'(TRIG_MIN_TICKS * CLK_DIV);
    localparam logic [31:0] DelayCyc   = 32'(ECHO_DELAY_TICKS * CLK_DIV);
    localparam logic [31:0] HoldCyc    = 32'(HOLDOFF_TICKS * CLK_DIV);
    localparam logic [31:0] SubMax     = 32'(CLK_DIV - 1);
    localparam logic [15:0] MaxEcho    = 16'(MAX_ECHO_TICKS);

    typedef enum logic [2:0] {StIdle, StTrig, StDelay, StEcho, StHoldoff} state_e;

    state_e      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_sub;
    logic [15:0] r_tick;
    logic [15:0] r_width;
    logic        r_echo;
    logic        r_busy;
    logic [7:0]  r_pulse_count;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_trig_d;
    logic [1:0]  r_seen;
    logic        r_armed;

    logic        w_rise;
    logic        w_fall;
    logic        w_accept;
    logic [15:0] w_dist_clamped;
    logic [15:0] w_width;

    assign w_rise   = r_sync2 & ~r_trig_d;
    assign w_fall   = ~r_sync2 & r_trig_d;
    assign w_accept = (r_state == StTrig) && w_fall && (r_cnt >= TrigMinCyc);

    assign w_dist_clamped = ((bus.dist_ticks == 16'd0) || (bus.dist_ticks > MaxEcho)) ?
                            MaxEcho : bus.dist_ticks;

    // Synchronise trigger; arm only after a genuine low has been seen since reset,
    // so a trigger held high through reset must fall and rise again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_trig_d <= 1'b0;
            r_seen   <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_sync1  <= bus.trigger;
            r_sync2  <= r_sync1;
            r_trig_d <= r_sync2;
            r_seen   <= {r_seen[0], 1'b1};
            if (r_seen[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef HCSR04_EMULATOR_JITTER_EN
    logic [15:0] r_lfsr;
    logic [16:0] w_jit_sum;

    assign w_jit_sum = {1'b0, w_dist_clamped} + {15'd0, r_lfsr[1:0]};
    assign w_width   = (w_jit_sum > {1'b0, MaxEcho}) ? MaxEcho : w_jit_sum[15:0];

    // Fibonacci LFSR, taps 16,14,13,11; steps once per accepted trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end
`else
    assign w_width = w_dist_clamped;
`endif

    // Main sequencer: trigger qualification, burst delay, echo, holdoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_sub         <= '0;
            r_tick        <= '0;
            r_width       <= '0;
            r_echo        <= 1'b0;
            r_busy        <= 1'b0;
            r_pulse_count <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_rise && r_armed) begin
                        r_state <= StTrig;
                        r_cnt   <= 32'd1;  // the cycle that showed the rise counts
                        r_busy  <= 1'b1;
                    end
                end
                StTrig: begin
                    if (w_fall) begin
                        if (w_accept) begin
                            r_width       <= w_width;
                            r_pulse_count <= r_pulse_count + 8'd1;
                            r_cnt         <= '0;
                            r_state       <= StDelay;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_cnt < TrigMinCyc) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                StDelay: begin
                    if (r_cnt == DelayCyc) begin
                        r_state <= StEcho;
                        r_echo  <= 1'b1;
                        r_sub   <= '0;
                        r_tick  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                StEcho: begin
                    if (r_sub == SubMax) begin
                        r_sub <= '0;
                        if (r_tick == r_width - 16'd1) begin
                            r_echo <= 1'b0;
                            if (HOLDOFF_TICKS > 0) begin
                                r_state <= StHoldoff;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_tick <= r_tick + 16'd1;
                        end
                    end else begin
                        r_sub <= r_sub + 32'd1;
                    end
                end
                StHoldoff: begin
                    if (r_cnt == HoldCyc - 32'd1) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_echo  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.echo        = r_echo;
    assign bus.busy        = r_busy;
    assign bus.pulse_count = r_pulse_count;
endmodule
